// File: rtl/merge_input_loader_if.sv
// Handshake bundle between the key source, the loader and the merge4to8 capture stage.
// slave is the loader side; master is the side that feeds keys and acknowledges frames.
interface merge_input_loader_if #(
  parameter int WIDTH = 3,
  parameter int n     = 4,
  parameter int CW    = $clog2(2*n+1)
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             flush;
  logic [n*WIDTH-1:0] a;
  logic [n*WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_count;

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, a, b, out_valid, out_count
  );

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, a, b, out_valid, out_count
  );
endinterface

// File: rtl/merge_input_loader.sv
// Serial key loader: insertion-sorts n keys into bank A, then n into bank B,
// and holds both banks as merger operands until the downstream stage acknowledges.
//   state  | meaning
//   FILL_A | accepting keys into bank A
//   FILL_B | accepting keys into bank B
//   HOLD   | frame complete, waiting for out_ready
module merge_input_loader #(
  parameter int WIDTH = 3,
  parameter int n     = 4,
  localparam int CW   = $clog2(2*n+1)
) (
  input logic clk,
  input logic rst_n,
  merge_input_loader_if.slave bus
);
  localparam int CNTW = $clog2(n+1);

  typedef enum logic [1:0] {
    FILL_A = 2'd0,
    FILL_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t               state;
  logic [n*WIDTH-1:0]   bank_a;
  logic [n*WIDTH-1:0]   bank_b;
  logic [n*WIDTH-1:0]   ins_a;
  logic [n*WIDTH-1:0]   ins_b;
  logic [CNTW-1:0]      cnt_a;
  logic [CNTW-1:0]      cnt_b;
  logic [CW-1:0]        count;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 accept;

  // Filled slots <= key form a prefix of the sorted bank, so each slot either keeps
  // its value, takes the new key, or takes its lower neighbour (shift up by one).
  function automatic logic [n*WIDTH-1:0] insert_key(
    input logic [n*WIDTH-1:0] bank,
    input logic [CNTW-1:0]    filled,
    input logic [WIDTH-1:0]   key
  );
    logic [n-1:0]       le;
    logic [n-1:0]       le_prev;
    logic [n*WIDTH-1:0] shifted;
    logic [n*WIDTH-1:0] res;
    for (int i = 0; i < n; i++) begin
      le[i] = (i < int'(filled)) && (bank[i*WIDTH +: WIDTH] <= key);
    end
    le_prev = {le[n-2:0], 1'b1};
    shifted = {bank[(n-1)*WIDTH-1:0], {WIDTH{1'b1}}};
    for (int i = 0; i < n; i++) begin
      if (le[i])
        res[i*WIDTH +: WIDTH] = bank[i*WIDTH +: WIDTH];
      else if (le_prev[i])
        res[i*WIDTH +: WIDTH] = key;
      else
        res[i*WIDTH +: WIDTH] = shifted[i*WIDTH +: WIDTH];
    end
    return res;
  endfunction

  always_comb begin
    ins_a = insert_key(bank_a, cnt_a, bus.in_data);
    ins_b = insert_key(bank_b, cnt_b, bus.in_data);
  end

  assign accept        = bus.in_valid & in_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.a         = bank_a;
  assign bus.b         = bank_b;
  assign bus.out_count = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL_A;
      bank_a      <= '1;
      bank_b      <= '1;
      cnt_a       <= '0;
      cnt_b       <= '0;
      count       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        FILL_A: begin
          if (accept) begin
            bank_a <= ins_a;
            cnt_a  <= cnt_a + CNTW'(1);
            count  <= count + CW'(1);
          end
          // An empty bank A with no key arriving means there is no frame to close.
          if (bus.flush && (accept || cnt_a != '0)) begin
            state       <= HOLD;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end else if (accept && cnt_a == CNTW'(n-1)) begin
            state <= FILL_B;
          end
        end
        FILL_B: begin
          if (accept) begin
            bank_b <= ins_b;
            cnt_b  <= cnt_b + CNTW'(1);
            count  <= count + CW'(1);
          end
          if (bus.flush || (accept && cnt_b == CNTW'(n-1))) begin
            state       <= HOLD;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state       <= FILL_A;
            bank_a      <= '1;
            bank_b      <= '1;
            cnt_a       <= '0;
            cnt_b       <= '0;
            count       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= FILL_A;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_merge_input_loader.sv
// Self-checking bench for merge_input_loader: directed plan scenarios plus
// randomized frames checked against a sort-and-pad reference model.
module tb_merge_input_loader;
  localparam int W  = 3;
  localparam int N  = 4;
  localparam int CW = $clog2(2*N+1);
  localparam logic [N*W-1:0] PAD = '1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int vectors     = 0;
  int miscompares = 0;

  merge_input_loader_if #(.WIDTH(W), .n(N)) bus();

  merge_input_loader #(.WIDTH(W), .n(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: take the bank's share of the key list, sort it, pad the rest.
  function automatic logic [N*W-1:0] model_bank(input int keys[$], input int first);
    int v[$];
    logic [N*W-1:0] r;
    for (int i = first; i < first + N && i < keys.size(); i++) v.push_back(keys[i]);
    v.sort();
    r = '1;
    foreach (v[i]) r[i*W +: W] = W'(v[i]);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic send(input int key, input bit fl);
    int guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = W'(key);
    bus.flush    = fl;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) begin
      miscompares++;
      $display("FAIL send_timeout: in_ready stuck at %b, required 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic flush_pulse();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({bus.a, bus.b} !== {PAD, PAD}) begin
      miscompares++; $display("FAIL reset_banks: got %h required %h", {bus.a, bus.b}, {PAD, PAD});
    end
    vectors++;
    if ({bus.out_valid, bus.in_ready, bus.out_count} !== {1'b0, 1'b1, CW'(0)}) begin
      miscompares++;
      $display("FAIL reset_ctrl: got valid=%b ready=%b count=%0d required 0/1/0",
               bus.out_valid, bus.in_ready, bus.out_count);
    end
  endtask

  task automatic test_stream();
    int keys[8] = '{5, 1, 7, 3, 2, 2, 0, 6};
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(keys[i], 1'b0);
      vectors++;
      if (bus.out_count !== CW'(i + 1)) begin
        miscompares++; $display("FAIL stream_count: got %0d required %0d", bus.out_count, i + 1);
      end
      vectors++;
      if (bus.out_valid !== (i == 7)) begin
        miscompares++; $display("FAIL stream_valid_%0d: got %b required %b", i, bus.out_valid, i == 7);
      end
    end
    vectors++;
    if ({bus.a, bus.b} !== {3'd7, 3'd5, 3'd3, 3'd1, 3'd6, 3'd2, 3'd2, 3'd0}) begin
      miscompares++; $display("FAIL stream_frame: got %h required a=1,3,5,7 b=0,2,2,6", {bus.a, bus.b});
    end
    step();
    vectors++;
    if ({bus.out_valid, bus.in_ready, bus.out_count, bus.a} !== {1'b0, 1'b1, CW'(0), PAD}) begin
      miscompares++;
      $display("FAIL stream_release: got valid=%b ready=%b count=%0d a=%h required 0/1/0/%h",
               bus.out_valid, bus.in_ready, bus.out_count, bus.a, PAD);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back_hold();
    int keys[$];
    logic [N*W-1:0] ea, eb;
    int x;
    do_reset();
    for (int i = 0; i < 2*N; i++) keys.push_back($urandom_range(0, 7));
    foreach (keys[i]) send(keys[i], 1'b0);
    ea = model_bank(keys, 0);
    eb = model_bank(keys, N);
    x = $urandom_range(0, 6);
    bus.in_valid = 1'b1;
    bus.in_data  = W'(x);
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if ({bus.out_valid, bus.in_ready, bus.a, bus.b, bus.out_count} !== {1'b1, 1'b0, ea, eb, CW'(8)}) begin
        miscompares++;
        $display("FAIL hold_stable_%0d: got v=%b r=%b ab=%h cnt=%0d required 1/0/%h/8",
                 c, bus.out_valid, bus.in_ready, {bus.a, bus.b}, bus.out_count, {ea, eb});
      end
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    vectors++;
    if ({bus.out_valid, bus.in_ready, bus.out_count} !== {1'b0, 1'b1, CW'(0)}) begin
      miscompares++;
      $display("FAIL hold_handshake: got v=%b r=%b cnt=%0d required 0/1/0",
               bus.out_valid, bus.in_ready, bus.out_count);
    end
    step();
    bus.in_valid = 1'b0;
    vectors++;
    if ({bus.a, bus.out_count} !== {{((N-1)*W){1'b1}}, W'(x), CW'(1)}) begin
      miscompares++; $display("FAIL hold_first_key: got a=%h cnt=%0d required slot0=%0d cnt=1",
                              bus.a, bus.out_count, x);
    end
  endtask

  task automatic test_flush();
    for (int variant = 0; variant < 2; variant++) begin
      do_reset();
      send(4, 1'b0);
      send(1, 1'b0);
      if (variant == 0) begin
        send(6, 1'b0);
        flush_pulse();
      end else begin
        send(6, 1'b1);
      end
      vectors++;
      if ({bus.out_valid, bus.a, bus.b, bus.out_count} !== {1'b1, 3'd7, 3'd6, 3'd4, 3'd1, PAD, CW'(3)}) begin
        miscompares++;
        $display("FAIL flush_v%0d: got v=%b a=%h b=%h cnt=%0d required 1 a=1,4,6,7 b=pad cnt=3",
                 variant, bus.out_valid, bus.a, bus.b, bus.out_count);
      end
    end
  endtask

  task automatic test_ties();
    int keys[6] = '{3, 3, 3, 0, 3, 3};
    do_reset();
    foreach (keys[i]) send(keys[i], 1'b0);
    flush_pulse();
    vectors++;
    if ({bus.out_valid, bus.a, bus.b, bus.out_count} !==
        {1'b1, 3'd3, 3'd3, 3'd3, 3'd0, 3'd7, 3'd7, 3'd3, 3'd3, CW'(6)}) begin
      miscompares++;
      $display("FAIL ties: got v=%b a=%h b=%h cnt=%0d required a=0,3,3,3 b=3,3,7,7 cnt=6",
               bus.out_valid, bus.a, bus.b, bus.out_count);
    end
  endtask

  task automatic test_empty_flush();
    int keys[$];
    do_reset();
    flush_pulse();
    step();
    vectors++;
    if ({bus.out_valid, bus.in_ready, bus.out_count} !== {1'b0, 1'b1, CW'(0)}) begin
      miscompares++;
      $display("FAIL empty_flush: got v=%b r=%b cnt=%0d required 0/1/0",
               bus.out_valid, bus.in_ready, bus.out_count);
    end
    for (int i = 0; i < 2*N; i++) keys.push_back($urandom_range(0, 7));
    foreach (keys[i]) send(keys[i], 1'b0);
    vectors++;
    if ({bus.out_valid, bus.a, bus.b} !== {1'b1, model_bank(keys, 0), model_bank(keys, N)}) begin
      miscompares++;
      $display("FAIL empty_flush_frame: got v=%b ab=%h required 1/%h",
               bus.out_valid, {bus.a, bus.b}, {model_bank(keys, 0), model_bank(keys, N)});
    end
  endtask

  task automatic test_async_reset();
    int keys[$];
    do_reset();
    for (int i = 0; i < 5; i++) send($urandom_range(0, 6), 1'b0);
    vectors++;
    if (bus.out_count !== CW'(5)) begin
      miscompares++; $display("FAIL async_pre_count: got %0d required 5", bus.out_count);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.out_valid, bus.out_count, bus.a, bus.b} !== {1'b0, CW'(0), PAD, PAD}) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b cnt=%0d ab=%h required 0/0/all-ones",
               bus.out_valid, bus.out_count, {bus.a, bus.b});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 2*N; i++) keys.push_back($urandom_range(0, 7));
    foreach (keys[i]) send(keys[i], 1'b0);
    vectors++;
    if ({bus.out_valid, bus.a, bus.b, bus.out_count} !==
        {1'b1, model_bank(keys, 0), model_bank(keys, N), CW'(8)}) begin
      miscompares++;
      $display("FAIL async_after: got v=%b ab=%h cnt=%0d required 1/%h/8",
               bus.out_valid, {bus.a, bus.b}, bus.out_count, {model_bank(keys, 0), model_bank(keys, N)});
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int f = 0; f < 25; f++) begin
      int keys[$];
      int len;
      bit coincident;
      len = $urandom_range(1, 2*N);
      coincident = bit'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) keys.push_back($urandom_range(0, 7));
      for (int i = 0; i < len; i++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) step();
        send(keys[i], (len < 2*N) && coincident && (i == len - 1));
      end
      if (len < 2*N && !coincident) flush_pulse();
      vectors++;
      if ({bus.out_valid, bus.in_ready, bus.a, bus.b, bus.out_count} !==
          {1'b1, 1'b0, model_bank(keys, 0), model_bank(keys, N), CW'(len)}) begin
        miscompares++;
        $display("FAIL random_frame_%0d: got v=%b r=%b ab=%h cnt=%0d required 1/0/%h/%0d",
                 f, bus.out_valid, bus.in_ready, {bus.a, bus.b}, bus.out_count,
                 {model_bank(keys, 0), model_bank(keys, N)}, len);
      end
      for (int g = $urandom_range(0, 3); g > 0; g--) step();
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      vectors++;
      if ({bus.out_valid, bus.out_count, bus.a, bus.b} !== {1'b0, CW'(0), PAD, PAD}) begin
        miscompares++;
        $display("FAIL random_release_%0d: got v=%b cnt=%0d ab=%h required 0/0/all-ones",
                 f, bus.out_valid, bus.out_count, {bus.a, bus.b});
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_stream();
    test_back_to_back_hold();
    test_flush();
    test_ties();
    test_empty_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/merge_input_loader.md
Name: merge_input_loader

Overview:
- Upstream feeder for merge4to8 in the V2V sorter path.
- Accepts a serial stream of WIDTH-bit keys through a valid/ready handshake. Insertion-sorts the first n keys into bank A and the next n keys into bank B, so each bank is ascending.
- Presents both banks to the combinational merger as its a/b operands and holds them until the downstream capture stage acknowledges.

Parameters:
- WIDTH, 3, bit width of one key; matches the merger's WIDTH.
- n, 4, keys per bank; matches the merger's n.
- CW, $clog2(2*n+1), width of out_count (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  WIDTH  incoming key.
- in_ready  output  1  loader accepts a key this cycle.
- flush  input  1  close the current frame early; unfilled slots stay padded.
- a  output  n*WIDTH  bank A, ascending; slice 0 (bits WIDTH-1:0) is the smallest.
- b  output  n*WIDTH  bank B, same ordering as a.
- out_valid  output  1  a/b hold a complete frame.
- out_ready  input  1  downstream has captured the merger output.
- out_count  output  CW  number of real (non-pad) keys in the frame, 0..2n.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=FILL_A; every slot of a and b = all-ones (pad value).
  - fill count = 0; out_valid=0; out_count=0; in_ready=1 once rst_n deasserts.
- All state is registered. in_ready and out_valid decode from state only, with no combinational path from inputs.
- Accept condition: in_valid & in_ready at the rising edge.
- FSM FILL_A (in_ready=1):
  - Each accept inserts in_data into bank A at position p, where p = number of filled A slots with value <= in_data.
  - Filled slots at positions >= p shift up one slot; the top filled slot moves into the first pad slot.
  - Equal keys: the new key goes after existing equals (stable).
  - After the n-th accept into A, the next state is FILL_B.
- FSM FILL_B: identical insertion into bank B. After the n-th accept into B, the next state is HOLD.
- FSM HOLD:
  - in_ready=0, out_valid=1; a, b and out_count are stable.
  - on out_valid & out_ready at the edge: all slots reset to all-ones, counts cleared, next state FILL_A.
  - No key is accepted in the handshake cycle.
- Latency: the 2n-th accept at edge k gives out_valid=1 in cycle k+1.
- Flush:
  - Sampled in FILL_A/FILL_B.
  - If an accept happens in the same cycle, the key is inserted first, then the frame closes and the next state is HOLD.
  - Remaining slots keep the all-ones pad.
  - Flush in FILL_A with zero keys filled and no accept: ignored, no empty frame emitted.
  - Flush in HOLD: ignored.
- out_count = keys filled in A + keys filled in B; it updates on every accept.
- Pads compare as the maximum value, so the merger output keeps real keys first. A real key equal to all-ones is indistinguishable from a pad; out_count disambiguates.
- Reset mid-frame discards the partial frame immediately.
- out_ready while not in HOLD: ignored.
- in_valid while in HOLD: not accepted; the upstream source must hold the key.

Test Plan:
- Stream 5,1,7,3,2,2,0,6 with in_valid=1 continuously, out_ready=1:
  - a slices (0..3) = 1,3,5,7; b = 0,2,2,6; out_count=8.
  - out_valid rises the cycle after the 8th accept and drops the cycle after the handshake.
  - in_ready=1 again the following cycle.
- Full frame, then out_ready=0 for 5 cycles while in_valid=1:
  - a/b/out_valid stay constant; in_ready=0 throughout; no key is lost.
  - The first key after out_ready pulses lands in a slot 0.
- Accept 4,1,6, then flush=1 with in_valid=0:
  - HOLD with a = 1,4,6,7(pad); b = 7,7,7,7; out_count=3.
  - Variant: flush coincident with the 3rd accept gives the same result.
- Six keys 3,3,3,0,3,3, then flush:
  - a = 0,3,3,3; b = 3,3,7,7; out_count=6.
  - Checks stable tie insertion and a FILL_B flush.
- Flush pulse in FILL_A with no keys: state stays FILL_A, out_valid stays 0.
- Assert rst_n=0 after 5 accepts, asynchronously mid-cycle:
  - Outputs go to reset values immediately.
  - A following 8-key stream produces a correct frame with no remnants.
